// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared state encoding, GPIO field map and config decode for
// the FFT frame sequencer.
package fft_seq_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t CAPTURE = 2'd1;
  localparam state_t SKIP    = 2'd2;

  localparam int EN_BIT  = 0;
  localparam int AVG_LSB = 1;
  localparam int AVG_MSB = 5;
  localparam int THR_LSB = 6;
  localparam int THR_MSB = 10;

  typedef struct packed {
    logic       enable;
    logic [4:0] log_avg;
    logic [4:0] log_thr;
  } cfg_t;

  function automatic cfg_t decode_gpio(input logic [10:0] gpio);
    cfg_t c;
    c.enable  = gpio[EN_BIT];
    c.log_avg = gpio[AVG_MSB:AVG_LSB];
    c.log_thr = gpio[THR_MSB:THR_LSB];
    return c;
  endfunction

  // Frames discarded after each captured frame: 2^log_thr - 1 (fits in 32 bits).
  function automatic logic [31:0] skip_frames(input logic [4:0] log_thr);
    return (32'd1 << log_thr) - 32'd1;
  endfunction

  // Index of the last frame in an averaging set; log 31 wraps to all-ones.
  function automatic logic [30:0] set_limit(input logic [4:0] log_avg);
    return (31'd1 << log_avg) - 31'd1;
  endfunction

endpackage

// File: rtl/fft_seq_out_reg.sv
// fft_seq_out_reg: one-deep AXIS holding register. A sample offered while the
// register is full and not being drained is dropped and flagged as overrun.
module fft_seq_out_reg #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         overrun_clr,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         drop,
  output logic         overrun
);

  // Handshake: a beat transfers on a clock edge where out_valid && out_ready;
  // out_data/out_last stay stable while out_valid is high and out_ready is low.
  logic can_load;

  assign can_load = !out_valid || out_ready;
  assign drop     = in_valid && !can_load;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid && can_load) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
        out_last  <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: gates the filter stream into aligned FFT frames with
// throttling and averaging-set markers. Define FFT_SEQ_FRAME_COUNT_EN for frame/drop counters.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH_IN  = 16,
  parameter int AXIS_TDATA_WIDTH_OUT = 32,
  parameter int LOG_FFT_LENGTH       = 10
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [31:0]                     GPIO,
  input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S_AXIS_filter_tdata,
  input  logic                            S_AXIS_filter_tvalid,
  output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_fft_tdata,
  output logic                            M_AXIS_fft_tvalid,
  input  logic                            M_AXIS_fft_tready,
  output logic                            M_AXIS_fft_tlast,
  output logic                            avg_first,
  output logic                            avg_last,
  output logic                            overrun,
`ifdef FFT_SEQ_FRAME_COUNT_EN
  output logic [31:0]                     frame_count,
  output logic [15:0]                     drop_count,
`endif
  output logic [1:0]                      state_dbg
);

  cfg_t                            cfg;
  state_t                          state;
  logic [LOG_FFT_LENGTH-1:0]       sample_cnt;
  logic [31:0]                     skip_cnt;
  logic [4:0]                      thr_shadow;
  logic [4:0]                      avg_shadow;
  logic [4:0]                      avg_log;
  logic [30:0]                     set_cnt;
  logic                            en_q;
  logic                            cnt_max;
  logic                            frame_end;
  logic                            load_valid;
  logic                            start;
  logic                            en_rise;
  logic                            last_hs;
  logic                            drop;
  logic [AXIS_TDATA_WIDTH_OUT-1:0] sample_ext;
  logic                            unused_gpio;

  assign cfg         = decode_gpio(GPIO[10:0]);
  assign unused_gpio = ^GPIO[31:11];
  assign cnt_max     = &sample_cnt;
  assign frame_end   = S_AXIS_filter_tvalid && cnt_max;
  assign load_valid  = (state == CAPTURE) && S_AXIS_filter_tvalid;
  assign start       = (state == IDLE) && cfg.enable;
  assign en_rise     = cfg.enable && !en_q;
  assign last_hs     = M_AXIS_fft_tvalid && M_AXIS_fft_tready && M_AXIS_fft_tlast;
  assign sample_ext  = {{(AXIS_TDATA_WIDTH_OUT-AXIS_TDATA_WIDTH_IN){1'b0}}, S_AXIS_filter_tdata};
  assign state_dbg   = state;

  // The sample counter runs through dropped and skipped samples so every
  // captured frame begins on an input-aligned boundary.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      sample_cnt <= '0;
      skip_cnt   <= '0;
      thr_shadow <= '0;
      avg_shadow <= '0;
      en_q       <= 1'b0;
    end else begin
      en_q <= cfg.enable;
      case (state)
        IDLE: begin
          sample_cnt <= '0;
          if (cfg.enable) begin
            state      <= CAPTURE;
            thr_shadow <= cfg.log_thr;
            avg_shadow <= cfg.log_avg;
          end
        end
        CAPTURE: begin
          if (S_AXIS_filter_tvalid) begin
            sample_cnt <= sample_cnt + LOG_FFT_LENGTH'(1);
            if (cnt_max) begin
              thr_shadow <= cfg.log_thr;
              avg_shadow <= cfg.log_avg;
              if (!cfg.enable) begin
                state <= IDLE;
              end else if (cfg.log_thr != 5'd0) begin
                state    <= SKIP;
                skip_cnt <= '0;
              end
            end
          end
        end
        SKIP: begin
          if (!cfg.enable) begin
            state      <= IDLE;
            sample_cnt <= '0;
          end else if (S_AXIS_filter_tvalid) begin
            sample_cnt <= sample_cnt + LOG_FFT_LENGTH'(1);
            if (frame_end) begin
              if (skip_cnt == skip_frames(thr_shadow) - 32'd1) begin
                state      <= CAPTURE;
                thr_shadow <= cfg.log_thr;
                avg_shadow <= cfg.log_avg;
              end else begin
                skip_cnt <= skip_cnt + 32'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Averaging set position follows frames as they leave on the output side.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      set_cnt <= '0;
      avg_log <= '0;
    end else if (start) begin
      set_cnt <= '0;
      avg_log <= cfg.log_avg;
    end else if (last_hs) begin
      if (set_cnt == set_limit(avg_log)) begin
        set_cnt <= '0;
        avg_log <= avg_shadow;
      end else begin
        set_cnt <= set_cnt + 31'd1;
      end
    end
  end

  assign avg_first = M_AXIS_fft_tvalid && (set_cnt == 31'd0);
  assign avg_last  = M_AXIS_fft_tvalid && (set_cnt == set_limit(avg_log));

  fft_seq_out_reg #(.W(AXIS_TDATA_WIDTH_OUT)) u_out_reg (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_valid    (load_valid),
    .in_data     (sample_ext),
    .in_last     (cnt_max),
    .overrun_clr (en_rise),
    .out_data    (M_AXIS_fft_tdata),
    .out_valid   (M_AXIS_fft_tvalid),
    .out_ready   (M_AXIS_fft_tready),
    .out_last    (M_AXIS_fft_tlast),
    .drop        (drop),
    .overrun     (overrun)
  );

`ifdef FFT_SEQ_FRAME_COUNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else if (en_rise) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (last_hs) begin
        frame_count <= frame_count + 32'd1;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized frame-sequencer scenarios checked against
// a frame-level reference model of throttling, averaging flags and alignment.
module tb_fft_frame_sequencer;

  localparam int W_IN  = 16;
  localparam int W_OUT = 32;
  localparam int FRAME = 1024;
  localparam int W     = 35;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [31:0]      GPIO;
  logic [W_IN-1:0]  s_tdata;
  logic             s_tvalid;
  logic [W_OUT-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic             avg_first;
  logic             avg_last;
  logic             overrun;
  logic [1:0]       state_dbg;

  logic [W_IN-1:0]  in_q[$];
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     obs_q[$];
  int               n_pass = 0;
  int               n_total = 0;

  fft_frame_sequencer #(
    .AXIS_TDATA_WIDTH_IN  (W_IN),
    .AXIS_TDATA_WIDTH_OUT (W_OUT),
    .LOG_FFT_LENGTH       (10)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .GPIO                 (GPIO),
    .S_AXIS_filter_tdata  (s_tdata),
    .S_AXIS_filter_tvalid (s_tvalid),
    .M_AXIS_fft_tdata     (m_tdata),
    .M_AXIS_fft_tvalid    (m_tvalid),
    .M_AXIS_fft_tready    (m_tready),
    .M_AXIS_fft_tlast     (m_tlast),
    .avg_first            (avg_first),
    .avg_last             (avg_last),
    .overrun              (overrun),
    .state_dbg            (state_dbg)
  );

  // Clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // Output monitor: records every transferred beat
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready)
      obs_q.push_back({avg_first, avg_last, m_tlast, m_tdata});
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [W_IN-1:0] d);
    @(posedge aclk); #1;
    s_tvalid = v;
    s_tdata  = d;
    if (v) in_q.push_back(d);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic send(input int n, input int idle_pct);
    int sent = 0;
    while (sent < n) begin
      if (int'($urandom_range(0, 99)) < idle_pct) begin
        drive(1'b0, 16'($urandom));
      end else begin
        drive(1'b1, 16'($urandom));
        sent++;
      end
    end
  endtask

  task automatic start_test();
    @(posedge aclk); #1;
    aresetn  = 1'b0;
    GPIO     = 32'h0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    in_q.delete();
    obs_q.delete();
    exp_q.delete();
  endtask

  // Reference model: frame f of the input passes when f is a multiple of
  // 2^thr; passed frame j sits at position j mod 2^avg of its averaging set.
  function automatic void model_frames(input int thr, input int avg, input int nsamp);
    int f, j, k, per, set_len;
    exp_q.delete();
    per     = 1 << thr;
    set_len = 1 << avg;
    for (int i = 0; i < nsamp; i++) begin
      f = i / FRAME;
      if ((f % per) != 0) continue;
      j = f / per;
      k = j % set_len;
      exp_q.push_back({1'(k == 0), 1'(k == set_len - 1), 1'((i % FRAME) == FRAME - 1),
                       16'h0000, in_q[i]});
    end
  endfunction

  function automatic int beat_errors(output string first);
    int e = 0;
    first = "";
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        if (e == 0) first = $sformatf("beat %0d got %h want %h", i, obs_q[i], exp_q[i]);
        e++;
      end
    end
    return e;
  endfunction

  // Scenarios
  task automatic test_reset();
    aresetn  = 1'b0;
    GPIO     = 32'h0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_total++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0)
      $display("FAIL reset_axis: tvalid=%b tlast=%b tdata=%h, want all 0", m_tvalid, m_tlast, m_tdata);
    else n_pass++;
    n_total++;
    if ({avg_first, avg_last, overrun} !== 3'b000)
      $display("FAIL reset_flags: first/last/overrun=%b, want 000", {avg_first, avg_last, overrun});
    else n_pass++;
    n_total++;
    if (state_dbg !== fft_seq_pkg::IDLE)
      $display("FAIL reset_state: state=%0d, want IDLE", state_dbg);
    else n_pass++;
    aresetn = 1'b1;
    GPIO = 32'h1;
    idle(5);
    n_total++;
    if (m_tvalid !== 1'b0)
      $display("FAIL idle_no_input: tvalid=%b with no input, want 0", m_tvalid);
    else n_pass++;
  endtask

  task automatic test_throttle_avg();
    string msg;
    int errs;
    start_test();
    GPIO = 32'h85;
    idle(2);
    send(23 * FRAME, 10);
    idle(4);
    model_frames(2, 2, 23 * FRAME);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL throttle_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    errs = beat_errors(msg);
    n_total++;
    if (errs !== 0) $display("FAIL throttle_beats: %0d bad beats, first %s", errs, msg);
    else n_pass++;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL throttle_overrun: overrun=%b, want 0", overrun);
    else n_pass++;
  endtask

  task automatic test_continuous();
    string msg;
    int errs;
    start_test();
    GPIO = 32'h01;
    idle(2);
    send(3 * FRAME, 0);
    idle(4);
    model_frames(0, 0, 3 * FRAME);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL cont_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    errs = beat_errors(msg);
    n_total++;
    if (errs !== 0) $display("FAIL cont_beats: %0d bad beats, first %s", errs, msg);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    string msg;
    int errs;
    start_test();
    GPIO = 32'h01;
    idle(2);
    send(500, 20);
    GPIO = 32'h00;
    send(524 + 300, 20);
    idle(4);
    model_frames(0, 0, FRAME);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL endrop_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    errs = beat_errors(msg);
    n_total++;
    if (errs !== 0) $display("FAIL endrop_beats: %0d bad beats, first %s", errs, msg);
    else n_pass++;
    n_total++;
    if (state_dbg !== fft_seq_pkg::IDLE || m_tvalid !== 1'b0)
      $display("FAIL endrop_idle: state=%0d tvalid=%b, want IDLE and 0", state_dbg, m_tvalid);
    else n_pass++;
  endtask

  task automatic test_overrun();
    string msg;
    int errs, s, n;
    start_test();
    GPIO = 32'h01;
    idle(2);
    s = $urandom_range(100, 900);
    n = $urandom_range(1, 4);
    for (int i = 0; i < FRAME; i++) begin
      @(posedge aclk); #1;
      s_tvalid = 1'b1;
      s_tdata  = 16'($urandom);
      in_q.push_back(s_tdata);
      m_tready = !(i >= s && i < s + n);
      if (i == 1000) GPIO = 32'h00;
    end
    idle(4);
    model_frames(0, 0, FRAME);
    for (int k = 0; k < n; k++) exp_q.delete(s);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL ovr_count: got %0d beats, want %0d (stall %0d at %0d)", obs_q.size(), exp_q.size(), n, s);
    else n_pass++;
    errs = beat_errors(msg);
    n_total++;
    if (errs !== 0) $display("FAIL ovr_beats: %0d bad beats, first %s", errs, msg);
    else n_pass++;
    n_total++;
    if (overrun !== 1'b1) $display("FAIL ovr_set: overrun=%b, want 1", overrun);
    else n_pass++;
    idle(3);
    n_total++;
    if (overrun !== 1'b1) $display("FAIL ovr_sticky: overrun=%b in idle, want 1", overrun);
    else n_pass++;
    GPIO = 32'h01;
    idle(2);
    n_total++;
    if (overrun !== 1'b0) $display("FAIL ovr_clear: overrun=%b after enable edge, want 0", overrun);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    string msg;
    int errs;
    start_test();
    GPIO = 32'h01;
    idle(2);
    send(300, 0);
    n_total++;
    if (m_tvalid !== 1'b1) $display("FAIL areset_pre: tvalid=%b before reset, want 1", m_tvalid);
    else n_pass++;
    #2 aresetn = 1'b0;
    #1;
    n_total++;
    if ({m_tvalid, m_tlast, avg_first, avg_last, overrun} !== 5'b0 || m_tdata !== '0)
      $display("FAIL areset_now: valid/last/first/alast/ovr=%b tdata=%h, want 0",
               {m_tvalid, m_tlast, avg_first, avg_last, overrun}, m_tdata);
    else n_pass++;
    s_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    in_q.delete();
    obs_q.delete();
    idle(2);
    send(FRAME, 10);
    idle(4);
    model_frames(0, 0, FRAME);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL areset_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    errs = beat_errors(msg);
    n_total++;
    if (errs !== 0) $display("FAIL areset_beats: %0d bad beats, first %s", errs, msg);
    else n_pass++;
  endtask

  task automatic test_throttle_change();
    string msg;
    int errs;
    start_test();
    GPIO = 32'h01;
    idle(2);
    send(500, 0);
    GPIO = 32'hC1;
    send(9 * FRAME - 500, 0);
    idle(4);
    GPIO = 32'h00;
    model_frames(3, 0, 9 * FRAME);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL thrchg_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    errs = beat_errors(msg);
    n_total++;
    if (errs !== 0) $display("FAIL thrchg_beats: %0d bad beats, first %s", errs, msg);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_throttle_avg();
    test_continuous();
    test_enable_drop();
    test_overrun();
    test_async_reset();
    test_throttle_change();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
